// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button levels in, six BCD digits and status flags out.
//   master: drives btn_start/btn_lap/btn_clear, observes disp_bcd/running/lap_frozen/ovf
//   slave : the controller side
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_lap;
  logic btn_clear;
  logic [23:0] disp_bcd;
  logic running;
  logic lap_frozen;
  logic ovf;
  modport master(output btn_start, btn_lap, btn_clear, input disp_bcd, running, lap_frozen, ovf);
  modport slave(input btn_start, btn_lap, btn_clear, output disp_bcd, running, lap_frozen, ovf);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: RUN/PAUSE sequencer driving a cascaded MM:SS.cc BCD counter with lap freeze.
//   clk, rst : clock, asynchronous active-high reset
//   sw       : slave side of stopwatch_ctrl_if (buttons in; disp_bcd, running, lap_frozen, ovf out)
module stopwatch_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 100
) (
  input logic clk,
  input logic rst,
  stopwatch_ctrl_if.slave sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  // per-digit terminal values, {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
  localparam logic [23:0] LIM = 24'h595999;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_e;
  state_e st_q, st_d;
  logic [2:0] btn_q, edg;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0] cnt_q, cnt_d, cnt_inc, lap_q, lap_d, disp_q;
  logic lf_q, lf_d, ovf_q, ovf_d, run_q, tick, wrap, cy;
  assign edg = {sw.btn_clear, sw.btn_start, sw.btn_lap} & ~btn_q;
  assign tick = st_q == RUN && pre_q == PW'(DIV - 1);
  // ripple the carry digit by digit; a carry out of the top digit is the 59:59.99 wrap
  always_comb begin
    cy = 1'b1;
    cnt_inc = cnt_q;
    for (int i = 0; i < 6; i++) begin
      if (cy) cnt_inc[4*i+:4] = cnt_q[4*i+:4] == LIM[4*i+:4] ? 4'd0 : cnt_q[4*i+:4] + 4'd1;
      cy = cy & (cnt_q[4*i+:4] == LIM[4*i+:4]);
    end
    wrap = cy;
  end
  // clear beats start beats lap; a clear in RUN is ignored but still swallows the others
  always_comb begin
    st_d = st_q;
    pre_d = st_q == RUN ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
    cnt_d = tick ? cnt_inc : cnt_q;
    ovf_d = ovf_q | (tick & wrap);
    lap_d = lap_q;
    lf_d = lf_q;
    if (edg[2]) begin
      if (st_q != RUN) begin
        st_d = IDLE;
        pre_d = '0;
        cnt_d = '0;
        lap_d = '0;
        lf_d = 1'b0;
        ovf_d = 1'b0;
      end
    end else if (edg[1]) begin
      st_d = st_q == RUN ? PAUSED : RUN;
    end else if (edg[0]) begin
      if (st_q == RUN && !lf_q) begin
        lap_d = cnt_q;
        lf_d = 1'b1;
      end else if (st_q != IDLE) begin
        lf_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      btn_q <= '0;
      pre_q <= '0;
      cnt_q <= '0;
      lap_q <= '0;
      lf_q <= 1'b0;
      ovf_q <= 1'b0;
      disp_q <= '0;
      run_q <= 1'b0;
    end else begin
      st_q <= st_d;
      btn_q <= {sw.btn_clear, sw.btn_start, sw.btn_lap};
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      lap_q <= lap_d;
      lf_q <= lf_d;
      ovf_q <= ovf_d;
      disp_q <= lf_d ? lap_d : cnt_d;
      run_q <= st_d == RUN;
    end
  end
  assign sw.disp_bcd = disp_q;
  assign sw.running = run_q;
  assign sw.lap_frozen = lf_q;
  assign sw.ovf = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus against a centisecond-count model of the stopwatch.
module tb_stopwatch_ctrl;
  localparam int DIV = 10;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;
  localparam logic [2:0] B0 = 3'b000, BL = 3'b001, BS = 3'b010, BC = 3'b100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bit en = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_st = S_IDLE, m_pre = 0, m_t = 0, m_lap = 0;
  bit m_lf = 1'b0, m_ovf = 1'b0;
  bit [2:0] m_pb = '0;
  stopwatch_ctrl_if sw();
  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (.clk(clk), .rst(rst), .sw(sw));
  always #5 clk = ~clk;
  function automatic logic [23:0] bcd(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction
  task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got disp/run/lap/ovf=%h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic lit(input string nm, input logic [23:0] d, input logic r, input logic lf, input logic o);
    chk(nm, {sw.disp_bcd, sw.running, sw.lap_frozen, sw.ovf}, {d, r, lf, o});
  endtask
  task automatic mdl();
    bit [2:0] b, ev;
    bit run;
    int old_t;
    if (rst) begin
      m_st = S_IDLE; m_pre = 0; m_t = 0; m_lap = 0; m_lf = 0; m_ovf = 0; m_pb = '0;
      return;
    end
    b = {sw.btn_clear, sw.btn_start, sw.btn_lap};
    ev = b & ~m_pb;
    m_pb = b;
    run = m_st == S_RUN;
    old_t = m_t;
    if (run) begin
      if (m_pre == DIV - 1) begin
        m_pre = 0;
        m_t = (m_t + 1) % 360000;
        if (m_t == 0) m_ovf = 1;
      end else m_pre++;
    end
    if (ev[2]) begin
      if (!run) begin
        m_st = S_IDLE; m_pre = 0; m_t = 0; m_lap = 0; m_lf = 0; m_ovf = 0;
      end
    end else if (ev[1]) m_st = run ? S_PAUSED : S_RUN;
    else if (ev[0]) begin
      if (run && !m_lf) begin
        m_lap = old_t;
        m_lf = 1;
      end else if (m_st != S_IDLE && m_lf) m_lf = 0;
    end
  endtask
  task automatic step(input logic [2:0] b);
    @(negedge clk);
    {sw.btn_clear, sw.btn_start, sw.btn_lap} = b;
    @(posedge clk);
    mdl();
  endtask
  task automatic run_n(input int n, input logic [2:0] b);
    repeat (n) step(b);
  endtask
  always @(negedge clk)
    if (en && !rst)
      chk("cycle", {sw.disp_bcd, sw.running, sw.lap_frozen, sw.ovf},
          {bcd(m_lf ? m_lap : m_t), m_st == S_RUN, m_lf, m_ovf});
  initial begin
    {sw.btn_clear, sw.btn_start, sw.btn_lap} = B0;
    #3 rst = 1'b1;
    #1 lit("reset", 24'h000000, 0, 0, 0);
    step(B0);
    step(B0);
    #1 rst = 1'b0;
    en = 1'b1;
    step(BS);
    run_n(1000, B0);
    #1 lit("one_second", 24'h000100, 1, 0, 0);
    step(BS);
    step(BC);
    step(BS);
    run_n(55, B0);
    step(BS);
    run_n(500, B0);
    #1 lit("paused_hold", 24'h000005, 0, 0, 0);
    step(BS);
    run_n(45, B0);
    #1 lit("pause_resume", 24'h000010, 1, 0, 0);
    step(BS);
    step(BC);
    step(BS);
    run_n(370, B0);
    step(BL);
    #1 lit("lap_capture", 24'h000037, 1, 1, 0);
    run_n(300, B0);
    #1 lit("lap_held", 24'h000037, 1, 1, 0);
    step(BL);
    #1 lit("lap_release", 24'h000067, 1, 0, 0);
    run_n(7, B0);
    step(BL);
    #1 lit("lap_on_tick", 24'h000067, 1, 1, 0);
    step(B0);
    step(BL);
    #1 lit("lap_live", 24'h000068, 1, 0, 0);
    step(BS);
    step(BL);
    #1 lit("lap_paused_noop", 24'h000068, 0, 0, 0);
    en = 1'b0;
    force dut.cnt_q = 24'h595998;
    m_t = 359998;
    step(B0);
    #1 release dut.cnt_q;
    en = 1'b1;
    step(BS);
    run_n(7, B0);
    #1 lit("max_count", 24'h595999, 1, 0, 0);
    run_n(10, B0);
    #1 lit("wrap", 24'h000000, 1, 0, 1);
    run_n(10, B0);
    #1 lit("after_wrap", 24'h000001, 1, 0, 1);
    step(BS);
    step(BC);
    #1 lit("clear_ovf", 24'h000000, 0, 0, 0);
    step(BS);
    run_n(25, B0);
    step(BS);
    step(B0);
    step(BC | BS);
    #1 lit("clear_beats_start", 24'h000000, 0, 0, 0);
    step(B0);
    step(BS);
    run_n(30, B0);
    step(BC);
    run_n(20, B0);
    #1 lit("clear_in_run", 24'h000005, 1, 0, 0);
    step(BC | BL);
    #1 lit("clear_lap_in_run", 24'h000005, 1, 0, 0);
    step(BS);
    step(BC);
    run_n(50, BS);
    #1 lit("held_start", 24'h000004, 1, 0, 0);
    step(B0);
    #2 rst = 1'b1;
    #1 lit("async_reset", 24'h000000, 0, 0, 0);
    step(B0);
    #1 rst = 1'b0;
    step(BS);
    run_n(10, B0);
    #1 lit("after_reset", 24'h000001, 1, 0, 0);
    step(B0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
